// File: rtl/buffer_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_t  : FSM state encoding (IDLE / BURST)
//   FIFO_DATA_W  : word width used by the wrapper FIFO, the default arbiter width
//   owner_w()    : width of a producer index for a given producer count
package buffer_arb_pkg;

    localparam int FIFO_DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffer_write_arbiter_rr_pick.sv
// Round-robin requester search, purely combinational.
//   req       : request vector, one bit per producer
//   last      : index of the most recent grantee (ranks lowest)
//   grant_idx : first requester found scanning last+1, last+2, ... mod NUM_REQ
//   any       : at least one request is present
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int OWNER_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] last,
    output logic [OWNER_W-1:0] grant_idx,
    output logic               any
);

    // Scan from the farthest candidate to the nearest so the nearest
    // requester is the last one to overwrite grant_idx.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (req[idx]) begin
                grant_idx = OWNER_W'(idx);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter sharing the write port of the wrapper FIFO between
// NUM_REQ producers, one bounded burst per grant.
//   clk_1       : write-domain clock
//   rst         : synchronous active-high reset
//   req / din   : producer requests and flattened producer data
//   ack         : one-hot consume strobe back to the granted producer
//   buffer_full : FIFO full flag, stalls the burst
//   data_1 / data_1_en : FIFO write port
//   owner       : current or last grantee
//   busy        : high while a burst is in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick next requester after `last`, one cycle per grant
// BURST | `owner` holds the write port for up to MAX_BURST accepted words
module buffer_write_arbiter
    import buffer_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = FIFO_DATA_W,
    parameter  int MAX_BURST = 4,
    localparam int OWNER_W   = owner_w(NUM_REQ)
) (
    input  logic                      clk_1,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      buffer_full,
    output logic [DATA_W-1:0]         data_1,
    output logic                      data_1_en,
    output logic [OWNER_W-1:0]        owner,
    output logic                      busy
);

    arb_state_t         state;
    logic [OWNER_W-1:0] last;
    logic [3:0]         burst_cnt;

    logic [OWNER_W-1:0] pick_idx;
    logic               pick_any;
    logic               sel_req;
    logic [DATA_W-1:0]  sel_din;
    logic               accept;
    logic               final_word;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWNER_W (OWNER_W)
    ) u_rr_pick (
        .req       (req),
        .last      (last),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign sel_req    = req[owner];
    assign sel_din    = din[int'(owner)*DATA_W +: DATA_W];
    assign accept     = (state == BURST) && sel_req && !buffer_full;
    assign final_word = (burst_cnt == 4'(MAX_BURST - 1));
    assign busy       = (state == BURST);

    // Write port is a direct mux off the registered owner so a full flag
    // blocks the write in the very cycle it rises; reset masks it outright.
    always_comb begin
        ack       = '0;
        data_1    = '0;
        data_1_en = 1'b0;
        if (!rst && accept) begin
            ack[owner] = 1'b1;
            data_1     = sel_din;
            data_1_en  = 1'b1;
        end
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= OWNER_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!sel_req) begin
                        state <= IDLE;
                        last  <= owner;
                    end else if (accept) begin
                        if (final_word) begin
                            state     <= IDLE;
                            last      <= owner;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
module tb_buffer_write_arbiter;

    typedef struct {
        logic        busy;
        logic [3:0]  ack;
        logic [15:0] data;
    } exp_t;

    logic        clk_1 = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] din;
    logic [3:0]  ack;
    logic        buffer_full;
    logic [15:0] data_1;
    logic        data_1_en;
    logic [1:0]  owner;
    logic        busy;

    logic [15:0] base [4];
    logic [15:0] ptr  [4];
    exp_t        sb [$];
    int          vectors    = 0;
    int          miscompares = 0;

    always #5 clk_1 = ~clk_1;

    buffer_write_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (16),
        .MAX_BURST (4)
    ) dut (
        .clk_1       (clk_1),
        .rst         (rst),
        .req         (req),
        .din         (din),
        .ack         (ack),
        .buffer_full (buffer_full),
        .data_1      (data_1),
        .data_1_en   (data_1_en),
        .owner       (owner),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_ptrs();
        for (int k = 0; k < 4; k++) ptr[k] = 16'd0;
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the
    // falling edge, then let producers advance on the words acknowledged.
    task automatic step(input logic r_rst, input logic [3:0] r_req, input logic r_full,
                        input logic e_busy, input logic [3:0] e_ack, input logic [15:0] e_data,
                        input string tag);
        exp_t       e;
        logic [3:0] obs_ack;
        rst         = r_rst;
        req         = r_req;
        buffer_full = r_full;
        for (int k = 0; k < 4; k++) din[k*16 +: 16] = base[k] + ptr[k];
        sb.push_back('{busy: e_busy, ack: e_ack, data: e_data});
        @(negedge clk_1);
        e = sb.pop_front();
        chk({tag, ".ack"},  16'(ack),       16'(e.ack));
        chk({tag, ".en"},   16'(data_1_en), 16'(e.ack != 4'd0));
        chk({tag, ".data"}, data_1,         e.data);
        chk({tag, ".busy"}, 16'(busy),      16'(e.busy));
        obs_ack = ack;
        @(posedge clk_1);
        #1;
        for (int k = 0; k < 4; k++) if (obs_ack[k]) ptr[k] = ptr[k] + 16'd1;
    endtask

    initial begin
        base[0] = 16'hA000;
        base[1] = 16'hB000;
        base[2] = 16'hC000;
        base[3] = 16'hD000;
        clear_ptrs();
        rst = 1'b1; req = 4'd0; buffer_full = 1'b0; din = '0;
        repeat (2) @(posedge clk_1);
        @(negedge clk_1);
        chk("rst.ack",   16'(ack),       16'd0);
        chk("rst.en",    16'(data_1_en), 16'd0);
        chk("rst.busy",  16'(busy),      16'd0);
        chk("rst.owner", 16'(owner),     16'd0);
        @(posedge clk_1);
        #1;

        // single producer: burst of 4, one idle cycle, then remaining 2 words
        step(0, 4'b0001, 0, 0, 4'b0000, 16'h0000, "t1.idle0");
        for (int j = 0; j < 4; j++)
            step(0, 4'b0001, 0, 1, 4'b0001, 16'hA000 + 16'(j), "t1.burst0");
        step(0, 4'b0001, 0, 0, 4'b0000, 16'h0000, "t1.idle1");
        step(0, 4'b0001, 0, 1, 4'b0001, 16'hA004, "t1.burst1a");
        step(0, 4'b0001, 0, 1, 4'b0001, 16'hA005, "t1.burst1b");
        step(0, 4'b0000, 0, 1, 4'b0000, 16'h0000, "t1.drop");
        step(0, 4'b0000, 0, 0, 4'b0000, 16'h0000, "t1.rest");

        // all producers requesting: rotate 0,1,2,3,0
        step(1, 4'b0000, 0, 0, 4'b0000, 16'h0000, "t2.rst");
        clear_ptrs();
        for (int o = 0; o < 5; o++) begin
            step(0, 4'b1111, 0, 0, 4'b0000, 16'h0000, "t2.idle");
            for (int j = 0; j < 4; j++) begin
                step(0, 4'b1111, 0, 1, 4'(1 << (o % 4)),
                     base[o % 4] + 16'((o / 4) * 4 + j), "t2.word");
                if (j == 0) chk("t2.owner", 16'(owner), 16'(o % 4));
            end
        end
        step(0, 4'b0000, 0, 0, 4'b0000, 16'h0000, "t2.end");

        // owner 2 stalled 3 cycles mid-burst, then again on its final word
        step(1, 4'b0000, 0, 0, 4'b0000, 16'h0000, "t3.rst");
        clear_ptrs();
        step(0, 4'b0100, 0, 0, 4'b0000, 16'h0000, "t3.idle");
        step(0, 4'b0100, 0, 1, 4'b0100, 16'hC000, "t3.w0");
        step(0, 4'b0100, 0, 1, 4'b0100, 16'hC001, "t3.w1");
        for (int j = 0; j < 3; j++)
            step(0, 4'b0100, 1, 1, 4'b0000, 16'h0000, "t3.stall");
        step(0, 4'b0100, 0, 1, 4'b0100, 16'hC002, "t3.w2");
        step(0, 4'b0100, 1, 1, 4'b0000, 16'h0000, "t3.stall_final");
        step(0, 4'b0100, 0, 1, 4'b0100, 16'hC003, "t3.w3");
        step(0, 4'b0000, 0, 0, 4'b0000, 16'h0000, "t3.end");

        // owner 1 drops after one word; producer 3 is next
        step(1, 4'b0000, 0, 0, 4'b0000, 16'h0000, "t4.rst");
        clear_ptrs();
        step(0, 4'b1010, 0, 0, 4'b0000, 16'h0000, "t4.idle");
        step(0, 4'b1010, 0, 1, 4'b0010, 16'hB000, "t4.w0");
        chk("t4.owner1", 16'(owner), 16'd1);
        step(0, 4'b1000, 0, 1, 4'b0000, 16'h0000, "t4.drop");
        step(0, 4'b1000, 0, 0, 4'b0000, 16'h0000, "t4.idle2");
        step(0, 4'b1000, 0, 1, 4'b1000, 16'hD000, "t4.w3");
        chk("t4.owner3", 16'(owner), 16'd3);
        step(0, 4'b0000, 0, 1, 4'b0000, 16'h0000, "t4.drop3");

        // reset in the middle of an owner-0 burst
        step(1, 4'b0000, 0, 0, 4'b0000, 16'h0000, "t5.rst0");
        clear_ptrs();
        step(0, 4'b1001, 0, 0, 4'b0000, 16'h0000, "t5.idle");
        step(0, 4'b1001, 0, 1, 4'b0001, 16'hA000, "t5.w0");
        step(1, 4'b1001, 0, 1, 4'b0000, 16'h0000, "t5.rst_mid");
        step(0, 4'b1001, 0, 0, 4'b0000, 16'h0000, "t5.idle_after");
        step(0, 4'b1001, 0, 1, 4'b0001, 16'hA001, "t5.regrant");
        chk("t5.owner", 16'(owner), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
